// File: rtl/decoder_upsample_concat.sv
// First U-Net decoder stage: 2x nearest-neighbour upsampling of the bottleneck
// stream, each upsampled pixel followed by its skip-connection pixel (HWC order).
module decoder_upsample_concat #(
    parameter int unsigned IN_WIDTH      = 28,
    parameter int unsigned IN_HEIGHT     = 28,
    parameter int unsigned UP_CHANNELS   = 256,
    parameter int unsigned SKIP_CHANNELS = 128,
    parameter int unsigned DATA_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] up_data,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] skip_data,
    input  logic                  skip_valid,
    output logic                  skip_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CH_MAX = (UP_CHANNELS > SKIP_CHANNELS) ? UP_CHANNELS : SKIP_CHANNELS;
    localparam int unsigned CH_W   = (CH_MAX > 1) ? $clog2(CH_MAX) : 1;
    localparam int unsigned X_W    = (2 * IN_WIDTH > 1) ? $clog2(2 * IN_WIDTH) : 1;
    localparam int unsigned Y_W    = (2 * IN_HEIGHT > 1) ? $clog2(2 * IN_HEIGHT) : 1;
    localparam int unsigned DEPTH  = IN_WIDTH * UP_CHANNELS;
    localparam int unsigned A_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UP    = 2'd1,
        S_SKIP  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    logic [CH_W-1:0]       r_ch;
    logic [X_W-1:0]        r_x;
    logic [Y_W-1:0]        r_y;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_lbuf [DEPTH];

    logic                  w_stream;
    logic                  w_src_avail;
    logic                  w_can_load;
    logic                  w_load;
    logic                  w_ch_last_up;
    logic                  w_ch_last_skip;
    logic                  w_x_last;
    logic                  w_y_last;
    logic                  w_final;
    logic [A_W-1:0]        w_addr;
    logic [DATA_WIDTH-1:0] w_src_data;

    // Source selection: live up stream only on even row / even column, else line buffer.
    always_comb begin
        w_stream       = ~r_x[0] & ~r_y[0];
        w_addr         = A_W'(r_x >> 1) * A_W'(UP_CHANNELS) + A_W'(r_ch);
        w_ch_last_up   = (r_ch == CH_W'(UP_CHANNELS - 1));
        w_ch_last_skip = (r_ch == CH_W'(SKIP_CHANNELS - 1));
        w_x_last       = (r_x == X_W'(2 * IN_WIDTH - 1));
        w_y_last       = (r_y == Y_W'(2 * IN_HEIGHT - 1));
        w_can_load     = ~r_out_valid | out_ready;
        w_src_avail    = 1'b0;
        w_src_data     = '0;
        case (r_state)
            S_UP: begin
                w_src_avail = w_stream ? up_valid : 1'b1;
                w_src_data  = w_stream ? up_data : r_lbuf[w_addr];
            end
            S_SKIP: begin
                w_src_avail = skip_valid;
                w_src_data  = skip_data;
            end
            default: begin
                w_src_avail = 1'b0;
                w_src_data  = '0;
            end
        endcase
        w_load     = w_src_avail & w_can_load;
        w_final    = (r_state == S_SKIP) & w_ch_last_skip & w_x_last & w_y_last;
        up_ready   = (r_state == S_UP) & w_stream & w_load;
        skip_ready = (r_state == S_SKIP) & w_load;
    end

    // Control FSM, counters and the single-entry output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_out_data  <= w_src_data;
                r_out_valid <= 1'b1;
                r_out_last  <= w_final;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    // A start coinciding with the done pulse is deliberately dropped.
                    if (start && !r_done) begin
                        r_state <= S_UP;
                        r_busy  <= 1'b1;
                        r_ch    <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                S_UP: begin
                    if (w_load) begin
                        if (w_ch_last_up) begin
                            r_ch    <= '0;
                            r_state <= S_SKIP;
                        end else begin
                            r_ch <= r_ch + CH_W'(1);
                        end
                    end
                end
                S_SKIP: begin
                    if (w_load) begin
                        if (w_ch_last_skip) begin
                            r_ch <= '0;
                            if (w_x_last && w_y_last) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_state <= S_UP;
                                if (w_x_last) begin
                                    r_x <= '0;
                                    r_y <= r_y + Y_W'(1);
                                end else begin
                                    r_x <= r_x + X_W'(1);
                                end
                            end
                        end else begin
                            r_ch <= r_ch + CH_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_out_valid && out_ready && r_out_last) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line buffer holds one bottleneck row; contents need no reset.
    always_ff @(posedge clk) begin
        if (up_ready) begin
            r_lbuf[w_addr] <= up_data;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
